// File: rtl/audio_pkg.sv
// Shared constants, defaults and FSM encoding for the audio PWM playback stage.
package audio_pkg;

  localparam int SAMPLE_DIV  = 3175;
  localparam int PWM_BITS    = 10;
  localparam int FIFO_DEPTH  = 4;
  localparam int PRIME_LEVEL = 2;
  localparam int SAMPLE_W    = 16;
  localparam int MIDSCALE    = 1 << (PWM_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample stream from the RAM stage into the PWM playback stage.
interface audio_pwm_out_if;
  import audio_pkg::*;

  // Handshake: sample_in is held stable while sample_valid is high; a transfer
  // happens on any rising clk edge where sample_valid && sample_ready.
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);

endinterface

// File: rtl/audio_pwm_out_sample_fifo.sv
// Small power-of-two sample FIFO with push/pop/flush and an occupancy count.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_din,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [WIDTH-1:0]       o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count < CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Flush wins over everything happening on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio playback stage: buffers samples, releases one per sample period and
// drives a glitch-free PWM pin whose duty only changes at carrier wrap.
module audio_pwm_out #(
  parameter int SAMPLE_DIV  = audio_pkg::SAMPLE_DIV,
  parameter int PWM_BITS    = audio_pkg::PWM_BITS,
  parameter int FIFO_DEPTH  = audio_pkg::FIFO_DEPTH,
  parameter int PRIME_LEVEL = audio_pkg::PRIME_LEVEL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  audio_pwm_out_if.slave              s_if,
  output logic                        sample_tick,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic                        playing,
  output logic                        AudPWM,
  output logic                        AudSD,
  output audio_pkg::state_e           o_dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] o_dbg_count,
  output logic [PWM_BITS-1:0]         o_dbg_duty,
  output logic [PWM_BITS-1:0]         o_dbg_pwm_cnt
);
  import audio_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0]       TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [PWM_BITS-1:0] MID       = {1'b1, {(PWM_BITS-1){1'b0}}};

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CW-1:0]         w_count;
  logic [SAMPLE_W-1:0]   w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_leave;
  logic                  w_tick;
  logic [TW-1:0]         r_tick_cnt;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [PWM_BITS-1:0]   r_duty;
  logic [SAMPLE_W-1:0]   r_cur_sample;
  logic                  r_underrun;
  logic                  r_aud_pwm;

  // Two's complement to offset binary, keeping the top PWM_BITS bits.
  function automatic logic [PWM_BITS-1:0] level_of(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] ob;
    ob = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    return PWM_BITS'(ob >> (SAMPLE_W - PWM_BITS));
  endfunction

  assign s_if.sample_ready = (w_count < CW'(FIFO_DEPTH));
  assign w_push  = s_if.sample_valid && s_if.sample_ready;
  assign w_leave = (r_state != ST_IDLE) && !enable;
  assign w_tick  = (r_state == ST_PLAY) && (r_tick_cnt == TICK_LAST);
  assign w_pop   = w_tick && (w_count != '0);

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_leave),
    .i_din   (s_if.sample_in),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_state_nxt = ST_PRIME;
      ST_PRIME: begin
        if (!enable)                           w_state_nxt = ST_IDLE;
        else if (w_count >= CW'(PRIME_LEVEL))  w_state_nxt = ST_PLAY;
      end
      ST_PLAY:  if (!enable) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_tick_cnt <= '0;
    else if (r_state == ST_PLAY && !w_leave) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    else                                     r_tick_cnt <= '0;
  end

  // Duty is sampled from cur_sample only at the carrier wrap, so a pop mid-period
  // (or on the wrap edge itself) first shows up in the following period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm_cnt <= '0;
      r_duty    <= MID;
      r_aud_pwm <= 1'b0;
    end else if (r_state == ST_IDLE || w_leave) begin
      r_pwm_cnt <= '0;
      r_duty    <= MID;
      r_aud_pwm <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (r_pwm_cnt == '1) r_duty <= level_of(r_cur_sample);
      r_aud_pwm <= (r_pwm_cnt < r_duty);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_sample <= '0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_pop) r_cur_sample <= w_head;
      if (w_tick && w_count == '0) r_underrun <= 1'b1;
      else if (underrun_clr)       r_underrun <= 1'b0;
    end
  end

  assign sample_tick   = w_tick;
  assign underrun      = r_underrun;
  assign playing       = (r_state == ST_PLAY);
  assign AudSD         = (r_state != ST_IDLE);
  assign AudPWM        = r_aud_pwm;
  assign o_dbg_state   = r_state;
  assign o_dbg_count   = w_count;
  assign o_dbg_duty    = r_duty;
  assign o_dbg_pwm_cnt = r_pwm_cnt;

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Downstream playback stage for the sample RAM. Accepts 16-bit signed audio samples over a valid/ready handshake, buffers them in a 4-entry FIFO, and releases one sample per audio period (~31.5 kHz at 100 MHz). Each sample is converted to a glitch-free PWM duty cycle on the board audio output (`AudPWM`/`AudSD`). It also produces the sample-rate tick that paces address advance in the RAM stage.

## Interface
- `SAMPLE_DIV`, default 3175: clocks per audio sample (100 MHz / 3175 ≈ 31.496 kHz).
- `PWM_BITS`, default 10: PWM resolution; carrier period is 2^PWM_BITS clocks (≈97.7 kHz).
- `FIFO_DEPTH`, default 4: sample buffer entries (power of two).
- `PRIME_LEVEL`, default 2: FIFO occupancy required before playback starts.
- `clk` in 1: system clock, 100 MHz; the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: playback request.
- `sample_in` in 16: two's-complement sample.
- `sample_valid` in 1: `sample_in` is valid.
- `sample_ready` out 1: FIFO can accept; a transfer occurs on an edge with valid && ready.
- `sample_tick` out 1: one-cycle pulse per consumed sample period (PLAY only).
- `underrun` out 1: sticky; set when a tick finds the FIFO empty.
- `underrun_clr` in 1: clears `underrun`; a same-cycle set wins.
- `playing` out 1: high in PLAY.
- `AudPWM` out 1: PWM audio output, registered.
- `AudSD` out 1: amplifier enable; high in PRIME and PLAY.

## Operation
- **FSM states:**
  - IDLE: the reset state.
  - PRIME: IDLE→PRIME when `enable`=1.
  - PLAY: PRIME→PLAY when FIFO count ≥ `PRIME_LEVEL`.
  - Exit: PRIME or PLAY→IDLE when `enable`=0, on the next edge.
- **Leaving to IDLE:**
  - FIFO flushed (count=0).
  - Tick counter and PWM counter zeroed.
  - duty = midscale (2^(PWM_BITS-1)).
- **FIFO:**
  - `sample_ready` = (count < FIFO_DEPTH), combinational from count.
  - Push accepted in all states, including IDLE.
  - IDLE flush overrides any same-cycle push.
- **Tick counter:**
  - Runs 0..SAMPLE_DIV-1 in PLAY only.
  - `sample_tick`=1 while the count equals SAMPLE_DIV-1, then wraps to 0.
- **On tick:**
  - FIFO non-empty: pop the head into `cur_sample`.
  - FIFO empty: `cur_sample` holds its value and `underrun` is set.
  - Playback continues either way; there is no return to PRIME.
- **Conversion:** `level` = {~s[15], s[14:0]} >> (16-PWM_BITS), giving an unsigned offset-binary value.
  - 0x8000 → 0.
  - 0x0000 → 2^(PWM_BITS-1).
  - 0x7FFF → 2^PWM_BITS-1.
- **PWM counter:**
  - Free-running 0..2^PWM_BITS-1 in PRIME and PLAY.
  - `duty` reloads from `level(cur_sample)` only when the counter wraps to 0, so a pop mid-period never alters the current period.
  - `AudPWM` <= (pwm_cnt < duty); duty 0 gives constant low.
  - Maximum duty is 2^PWM_BITS-1, i.e. high for all but one clock.
- **Simultaneous events:**
  - Push and pop in the same cycle: count unchanged.
  - Push into an empty FIFO on a tick edge: underrun (the pop sees empty), and the pushed sample is retained.
- **Reset values (`rst` low, any time):**
  - State IDLE, FIFO count 0, `cur_sample`=0, duty midscale.
  - `sample_ready`=1.
  - `sample_tick`, `underrun`, `playing`, `AudPWM`, `AudSD` = 0.

## Timing
- Push-to-ready: `sample_ready` reflects the new count on the cycle after the push edge.
- PRIME→PLAY: one edge after count reaches `PRIME_LEVEL`. The first `sample_tick` occurs SAMPLE_DIV cycles after PLAY entry.
- Pop to `cur_sample` update: 1 cycle.
- `cur_sample` to `duty`: at the next PWM wrap, 1..2^PWM_BITS cycles later.
- `duty` to `AudPWM`: 1 cycle (registered).
- Worst-case sample-to-pin latency: SAMPLE_DIV×FIFO_DEPTH + 2^PWM_BITS + 2 cycles.
- `enable` fall: `playing`/`AudSD` low and `AudPWM` low after one edge.

## Structure
- Shared package/include `audio_pkg`:
  - `SAMPLE_DIV`, `PWM_BITS`.
  - Midscale constant.
  - FSM state encodings IDLE/PRIME/PLAY.
- Sub-module `sample_fifo`:
  - Parameterised depth/width.
  - Signals: push/pop/flush, count, head data.
  - Same async active-low reset.
- Top holds the FSM, tick counter, PWM counter and conversion.

## Test plan
- **Reset mid-PLAY:**
  - Stimulus: assert `rst` low while playing with 3 samples queued.
  - Response: all outputs at their reset values immediately; count 0 after release; `sample_ready`=1.
- **Prime and play:**
  - Stimulus: `enable`=1, push 0x7FFF then 0x8000.
  - Response: PLAY one edge after the second push; first tick SAMPLE_DIV cycles later; after the next wrap, `AudPWM` high 1023 of 1024 clocks.
- **Conversion points:**
  - Stimulus: play 0x0000, 0x8000, 0x4000.
  - Response: duty 512, 0 and 768 respectively; duty 0 gives `AudPWM` constantly low.
- **Full back-pressure:**
  - Stimulus: hold `sample_valid`=1 in IDLE.
  - Response: exactly 4 accepted; `sample_ready`=0 thereafter; rises one cycle after the first pop in PLAY.
- **Underrun:**
  - Stimulus: let the FIFO drain.
  - Response: at the tick on empty, `underrun`=1 and duty is held. Then, with `underrun_clr` pulsed on a non-tick cycle, `underrun` returns to 0; with it pulsed on a tick with the FIFO still empty, `underrun` stays 1.
- **Disable mid-period:**
  - Stimulus: drop `enable` with pwm_cnt=300.
  - Response: next edge gives IDLE, FIFO empty, `AudPWM`=0, `AudSD`=0, `sample_tick` silent.
